// File: rtl/inst_pkg.sv
// Package shared by the instruction encoder and the decoder.
// Holds the opcode constants, the instruction format enum, the FIFO state
// enum and a helper that maps an opcode to its format.
package inst_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL
   } fmt_e;

   typedef enum logic [1:0] {
      FIFO_EMPTY, FIFO_ONE, FIFO_FULL
   } fifo_state_e;

   function automatic fmt_e classify(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_LUI, OP_AUIPC:                              f = FMT_U;
         OP_JAL:                                        f = FMT_J;
         OP_BRANCH:                                     f = FMT_B;
         OP_STORE:                                      f = FMT_S;
         OP_OP:                                         f = FMT_R;
         OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM: f = FMT_I;
         default:                                       f = FMT_ILLEGAL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Two-entry, 32-bit valid/ready FIFO.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_wr_valid, o_wr_ready, i_wr_data  write side
//   o_rd_valid, i_rd_ready, o_rd_data  read side (o_rd_data is the head entry)
//
// state      | meaning
// FIFO_EMPTY | no entries, o_rd_valid=0, o_wr_ready=1
// FIFO_ONE   | head entry in mem0_q, o_rd_valid=1, o_wr_ready=1
// FIFO_FULL  | head in mem0_q, second in mem1_q, o_wr_ready=0
module inst_fifo
   import inst_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [31:0] i_wr_data,
   output logic        o_rd_valid,
   input  logic        i_rd_ready,
   output logic [31:0] o_rd_data
);

   fifo_state_e state_q;
   logic        valid_q;
   logic        ready_q;
   logic [31:0] mem0_q;
   logic [31:0] mem1_q;
   logic        push;
   logic        pop;

   assign push = i_wr_valid && ready_q;
   assign pop  = valid_q && i_rd_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= FIFO_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         mem0_q  <= '0;
         mem1_q  <= '0;
      end else begin
         case (state_q)
            FIFO_EMPTY: begin
               if (push) begin
                  mem0_q  <= i_wr_data;
                  state_q <= FIFO_ONE;
                  valid_q <= 1'b1;
               end
            end
            FIFO_ONE: begin
               if (push && pop) begin
                  mem0_q <= i_wr_data;
               end else if (push) begin
                  mem1_q  <= i_wr_data;
                  state_q <= FIFO_FULL;
                  ready_q <= 1'b0;
               end else if (pop) begin
                  state_q <= FIFO_EMPTY;
                  valid_q <= 1'b0;
               end
            end
            FIFO_FULL: begin
               // ready_q is low here, so a push cannot coincide with the pop
               if (pop) begin
                  mem0_q  <= mem1_q;
                  state_q <= FIFO_ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= FIFO_EMPTY;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_wr_ready = ready_q;
   assign o_rd_valid = valid_q;
   assign o_rd_data  = mem0_q;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs RISC-V style field sets into 32-bit words and
// buffers them in a 2-entry FIFO with valid/ready handshakes on both sides.
// Illegal field sets are handshaken but dropped, flagged by a one-cycle o_err.
// Optional build macro: INST_ENCODER_RANGE_CHECK_EN rejects I/S/B field sets
// whose imm[19:12] is not a sign extension of imm[11].
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_valid, o_ready               input handshake
//   i_op, i_rd, i_rs1, i_rs2       opcode and register fields
//   i_func                         [9:3]=funct7, [2:0]=funct3
//   i_imm                          20-bit immediate
//   o_valid, i_ready, o_inst       output handshake and encoded word
//   o_err                          pulse one cycle after a rejected accept
//   o_inst_cnt                     words pushed (wrapping)
//   o_err_cnt                      rejects (saturating)
module inst_encoder
   import inst_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [6:0]  i_op,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [9:0]  i_func,
   input  logic [19:0] i_imm,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_inst,
   output logic        o_err,
   output logic [15:0] o_inst_cnt,
   output logic [7:0]  o_err_cnt
);

   fmt_e        fmt;
   logic        legal;
   logic [31:0] inst_d;
   logic        fifo_ready;
   logic        accept;
   logic        push;
   logic        err_q;
   logic [15:0] inst_cnt_q;
   logic [7:0]  err_cnt_q;
   logic [6:0]  funct7;
   logic [2:0]  funct3;

   assign fmt    = classify(i_op);
   assign funct7 = i_func[9:3];
   assign funct3 = i_func[2:0];

   always_comb begin
      legal = (fmt != FMT_ILLEGAL);
`ifdef INST_ENCODER_RANGE_CHECK_EN
      if ((fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) &&
          (i_imm[19:12] != {8{i_imm[11]}}))
         legal = 1'b0;
`endif
   end

   always_comb begin
      inst_d = '0;
      case (fmt)
         FMT_R: inst_d = {funct7, i_rs2, i_rs1, funct3, i_rd, i_op};
         FMT_I: inst_d = {i_imm[11:0], i_rs1, funct3, i_rd, i_op};
         FMT_S: inst_d = {i_imm[11:5], i_rs2, i_rs1, funct3, i_imm[4:0], i_op};
         FMT_B: inst_d = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, funct3,
                          i_imm[3:0], i_imm[10], i_op};
         FMT_U: inst_d = {i_imm[19:0], i_rd, i_op};
         FMT_J: inst_d = {i_imm[19], i_imm[9:0], i_imm[10], i_imm[18:11],
                          i_rd, i_op};
         default: inst_d = '0;
      endcase
   end

   assign accept = i_valid && fifo_ready;
   assign push   = accept && legal;

   inst_fifo u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_valid (i_valid && legal),
      .o_wr_ready (fifo_ready),
      .i_wr_data  (inst_d),
      .o_rd_valid (o_valid),
      .i_rd_ready (i_ready),
      .o_rd_data  (o_inst)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_q      <= 1'b0;
         inst_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         err_q <= accept && !legal;
         if (push)
            inst_cnt_q <= inst_cnt_q + 16'd1;
         if (accept && !legal && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign o_ready    = fifo_ready;
   assign o_err      = err_q;
   assign o_inst_cnt = inst_cnt_q;
   assign o_err_cnt  = err_cnt_q;

endmodule
